fb_pixel_writer: RTL

Frame-buffer write engine; the writer counterpart of the VGA scan-out read path. Accepts an 8-bit byte stream (R, G, B per pixel, from the USB/host link), assembles 24-bit pixels, and writes them into the 640x480 frame memory. It uses the same linear mapping as display, address = y*640 + x. It sits between the host byte receiver and the write port of the dual-port frame RAM, whose read port feeds the VGA controller.

---
 rtl/fb_pkg.sv | 16 +
 rtl/fb_pixel_writer_if.sv | 28 ++
 rtl/fb_xy_counter.sv | 59 +++++
 rtl/fb_pixel_writer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry and writer state encoding.
package fb_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W   = 19;
  localparam int PIX_W    = 24;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    RECV     = 2'd1,
    WRITE    = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_pixel_writer_if.sv
// Byte stream in, frame-memory write port out.
interface fb_pixel_writer_if #(
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int PIX_W  = fb_pkg::PIX_W
);

  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_sof;
  logic              s_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_en;
  logic              wr_ack;

  // Host byte source and frame memory side
  modport master (
    output s_data, s_valid, s_sof, wr_ack,
    input  s_ready, wr_addr, wr_data, wr_en
  );

  // Pixel writer side
  modport slave (
    input  s_data, s_valid, s_sof, wr_ack,
    output s_ready, wr_addr, wr_data, wr_en
  );

endinterface

// File: rtl/fb_xy_counter.sv
// Raster x/y position counter for the frame writer.
module fb_xy_counter #(
  parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
  parameter int V_ACTIVE = fb_pkg::V_ACTIVE,
  localparam int X_W = $clog2(H_ACTIVE),
  localparam int Y_W = $clog2(V_ACTIVE)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last_pixel
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           x_last;
  logic           y_last;

  // End-of-line / end-of-frame decode
  always_comb begin
    x_last     = (x_q == X_W'(H_ACTIVE - 1));
    y_last     = (y_q == Y_W'(V_ACTIVE - 1));
    last_pixel = x_last && y_last;
    x          = x_q;
    y          = y_q;
  end

  // Next position: clear wins over advance; x wraps into the next line
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Position registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Assembles R,G,B bytes into pixels and writes them linearly into frame memory.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
  parameter int V_ACTIVE = fb_pkg::V_ACTIVE,
  parameter int ADDR_W   = fb_pkg::ADDR_W,
  parameter int PIX_W    = fb_pkg::PIX_W
) (
  input  logic               clk,
  input  logic               rst,
  fb_pixel_writer_if.slave   bus,
  output logic               frame_done,
  output logic               sync_err,
  output logic               busy
);

  localparam int X_W = $clog2(H_ACTIVE);
  localparam int Y_W = $clog2(V_ACTIVE);

  fb_state_e        state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       r_q, r_d;
  logic [7:0]       g_q, g_d;
  logic [PIX_W-1:0] wr_data_q, wr_data_d;
  logic             frame_done_q, frame_done_d;
  logic             sync_err_q, sync_err_d;
  logic             busy_q, busy_d;

  logic             cnt_clear;
  logic             cnt_advance;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             last_pixel;
  logic             ready;
  logic             accept;

  fb_xy_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_xy (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .advance    (cnt_advance),
    .x          (x),
    .y          (y),
    .last_pixel (last_pixel)
  );

  // Outputs: ready decodes registered state only; address from registered x/y
  always_comb begin
    ready       = (state_q != WRITE);
    accept      = bus.s_valid && ready;
    bus.s_ready = ready && !rst;
    bus.wr_en   = (state_q == WRITE);
    bus.wr_data = wr_data_q;
    bus.wr_addr = ADDR_W'(y) * ADDR_W'(H_ACTIVE) + ADDR_W'(x);
    frame_done  = frame_done_q;
    sync_err    = sync_err_q;
    busy        = busy_q;
  end

  // Byte assembly and write-handshake state machine
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    r_d          = r_q;
    g_d          = g_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    busy_d       = busy_q;
    cnt_clear    = 1'b0;
    cnt_advance  = 1'b0;
    unique case (state_q)
      WAIT_SOF: begin
        if (accept && bus.s_sof) begin
          r_d       = bus.s_data;
          idx_d     = 2'd1;
          cnt_clear = 1'b1;
          busy_d    = 1'b1;
          state_d   = RECV;
        end
      end
      RECV: begin
        if (accept) begin
          if (bus.s_sof) begin
            // Resync: partial pixel dropped, this byte restarts pixel (0,0)
            sync_err_d = 1'b1;
            r_d        = bus.s_data;
            idx_d      = 2'd1;
            cnt_clear  = 1'b1;
          end else begin
            unique case (idx_q)
              2'd0: begin
                r_d   = bus.s_data;
                idx_d = 2'd1;
              end
              2'd1: begin
                g_d   = bus.s_data;
                idx_d = 2'd2;
              end
              default: begin
                wr_data_d = PIX_W'({r_q, g_q, bus.s_data});
                idx_d     = 2'd0;
                state_d   = WRITE;
              end
            endcase
          end
        end
      end
      WRITE: begin
        if (bus.wr_ack) begin
          if (last_pixel) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            cnt_clear    = 1'b1;
            state_d      = WAIT_SOF;
          end else begin
            cnt_advance = 1'b1;
            state_d     = RECV;
          end
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_SOF;
      idx_q        <= '0;
      r_q          <= '0;
      g_q          <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      r_q          <= r_d;
      g_q          <= g_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      busy_q       <= busy_d;
    end
  end

endmodule
